memorybank_node: RTL and testbench

- Node-information storage bank: 64 entries × 16-bit words, addressed by a 6-bit index.
- Each word holds one nodeID/attribute record for the routing/clustering logic.
- Single synchronous write port, asynchronous (combinational) read port sharing the same index.
- Read by the neighbour/cluster-table logic; one instance per node table.

---
 rtl/memorybank_node_pkg.sv | 12 +
 rtl/memorybank_node.sv | 72 +++++++
 tb/tb_memorybank_node.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/memorybank_node_pkg.sv
// Shared sizing and types for the node-information storage bank.
// Optional entry counter is enabled by defining MEMORYBANK_NODE_COUNT_EN.
package memorybank_node_pkg;

  localparam int WORD_WIDTH  = 16;
  localparam int MEM_DEPTH   = 64;
  localparam int INDEX_WIDTH = $clog2(MEM_DEPTH);

  typedef logic [WORD_WIDTH-1:0]  node_word_t;
  typedef logic [INDEX_WIDTH-1:0] node_index_t;

endpackage

// File: rtl/memorybank_node.sv
// Node-information storage bank: 64 x 16-bit words, sync write, combinational read.
// Define MEMORYBANK_NODE_COUNT_EN to add the registered entry_count output.
module memorybank_node
  import memorybank_node_pkg::*;
(
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 wr_en,
  input  node_index_t          index,
  input  node_word_t           data_in,
  output node_word_t           data_out,
  output logic                 data_valid
`ifdef MEMORYBANK_NODE_COUNT_EN
  ,
  output logic [INDEX_WIDTH:0] entry_count
`endif
);

  node_word_t             r_mem [MEM_DEPTH];
  logic [MEM_DEPTH-1:0]   r_valid;

  // Storage and valid vector; reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= {WORD_WIDTH{1'b0}};
      end
      r_valid <= {MEM_DEPTH{1'b0}};
    end else if (wr_en) begin
      r_mem[index]   <= data_in;
      r_valid[index] <= 1'b1;
    end
  end

  node_word_t w_rd_data;
  logic       w_rd_valid;

  // Combinational read port; a same-index write only shows after the edge.
  always_comb begin
    w_rd_data  = r_mem[index];
    w_rd_valid = r_valid[index];
  end

  assign data_out   = w_rd_data;
  assign data_valid = w_rd_valid;

`ifdef MEMORYBANK_NODE_COUNT_EN
  logic [INDEX_WIDTH:0] r_count;
  logic                 w_new_entry;

  // Only a write to a not-yet-valid entry grows the population count.
  always_comb begin
    if (wr_en) begin
      w_new_entry = ~r_valid[index];
    end else begin
      w_new_entry = 1'b0;
    end
  end

  // Population counter, updated on the same edge as the valid vector.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_count <= {(INDEX_WIDTH+1){1'b0}};
    end else if (w_new_entry) begin
      r_count <= r_count + {{INDEX_WIDTH{1'b0}}, 1'b1};
    end
  end

  assign entry_count = r_count;
`endif

endmodule

// File: tb/tb_memorybank_node.sv
// Directed self-checking bench for memorybank_node (default and MEMORYBANK_NODE_COUNT_EN builds).
module tb_memorybank_node;
  import memorybank_node_pkg::*;

  logic        clk;
  logic        nrst;
  logic        wr_en;
  node_index_t index;
  node_word_t  data_in;
  node_word_t  data_out;
  logic        data_valid;
`ifdef MEMORYBANK_NODE_COUNT_EN
  logic [INDEX_WIDTH:0] entry_count;
`endif

  int checks = 0;
  int errors = 0;

  memorybank_node dut (
    .clk        (clk),
    .nrst       (nrst),
    .wr_en      (wr_en),
    .index      (index),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid)
`ifdef MEMORYBANK_NODE_COUNT_EN
    ,
    .entry_count(entry_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Illegal stimulus guard: the index must be known whenever a write is requested.
  always @(posedge clk) begin
    if (wr_en === 1'b1) begin
      assert (!$isunknown(index))
      else begin
        errors++;
        $error("FAIL x_index observed=%b expected=known", index);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int idx, input logic [15:0] d);
    index   = 6'(idx);
    data_in = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic expect_entry(input string tag, input int idx, input logic [15:0] d, input logic v);
    index = 6'(idx);
    #1;
    check({tag, "_data"}, 32'(data_out), 32'(d));
    check({tag, "_valid"}, 32'(data_valid), 32'(v));
  endtask

  task automatic expect_count(input string tag, input int n);
`ifdef MEMORYBANK_NODE_COUNT_EN
    check(tag, 32'(entry_count), 32'(n));
`else
    if (n < 0) $display("unused count %s", tag);
`endif
  endtask

  initial begin
    nrst    = 1'b0;
    wr_en   = 1'b0;
    index   = 6'd0;
    data_in = 16'h0000;
    repeat (2) tick();
    nrst = 1'b1;

    // Reset state across the whole index range.
    for (int i = 0; i < 64; i++) expect_entry("reset", i, 16'h0000, 1'b0);
    expect_count("reset_count", 0);

    // Basic writes.
    do_write(0, 16'd3);
    expect_entry("wr0", 0, 16'd3, 1'b1);
    do_write(2, 16'd15);
    expect_entry("wr2_keep0", 0, 16'd3, 1'b1);
    expect_entry("wr2", 2, 16'd15, 1'b1);

    // Hold with wr_en low and data_in wiggling.
    do_write(4, 16'd45);
    for (int k = 0; k < 5; k++) begin
      data_in = 16'($urandom);
      index   = 6'(k);
      tick();
    end
    expect_entry("hold4", 4, 16'd45, 1'b1);
    expect_entry("hold2", 2, 16'd15, 1'b1);
    expect_entry("hold0", 0, 16'd3, 1'b1);
    expect_entry("hold1", 1, 16'h0000, 1'b0);
    expect_count("hold_count", 3);

    // Read-during-write on the same index: old word until the edge.
    do_write(7, 16'h1111);
    expect_count("rdw_pre_count", 4);
    index   = 6'd7;
    data_in = 16'hBEEF;
    wr_en   = 1'b1;
    #1;
    check("rdw_before", 32'(data_out), 32'h1111);
    tick();
    wr_en = 1'b0;
    check("rdw_after", 32'(data_out), 32'hBEEF);
    do_write(7, 16'hBEEF);
    expect_entry("rewrite7", 7, 16'hBEEF, 1'b1);
    expect_count("rewrite_count", 4);

    // Index boundaries, no aliasing between 0 and 63.
    do_write(63, 16'hFFFF);
    do_write(0, 16'h0001);
    expect_entry("b63", 63, 16'hFFFF, 1'b1);
    expect_entry("b0", 0, 16'h0001, 1'b1);
    expect_entry("b62", 62, 16'h0000, 1'b0);
    expect_entry("b1", 1, 16'h0000, 1'b0);
    expect_count("bound_count", 5);

    // Fill every entry with a distinct pattern.
    for (int i = 0; i < 64; i++) do_write(i, 16'hA5A5 ^ 16'(i * 257));
    for (int i = 0; i < 64; i++) expect_entry("fill", i, 16'hA5A5 ^ 16'(i * 257), 1'b1);
    expect_count("full_count", 64);

    // Reset has priority over a concurrent write.
    nrst    = 1'b0;
    wr_en   = 1'b1;
    index   = 6'd5;
    data_in = 16'hAAAA;
    tick();
    nrst  = 1'b1;
    wr_en = 1'b0;
    expect_entry("rstprio5", 5, 16'h0000, 1'b0);
    for (int i = 0; i < 64; i++) expect_entry("rstclr", i, 16'h0000, 1'b0);
    expect_count("rstprio_count", 0);

    // Normal operation resumes after reset.
    do_write(9, 16'h0C0D);
    expect_entry("post9", 9, 16'h0C0D, 1'b1);
    expect_count("post_count", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
